// File: rtl/input_conditioner.sv
// Two-flop synchronizer plus per-channel debounce FSM for board buttons and switches.
// Optional INPUT_COND_AUTOREPEAT_EN adds held-button auto-repeat pulses.
module input_conditioner #(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned NUM_SW          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned RPT_W           = 26
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_SW-1:0]  sw_level
);

  localparam int unsigned     NumCh  = NUM_BTN + NUM_SW;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || ((64'(DEBOUNCE_CYCLES) - 64'd1) >> CNT_W) != 64'd0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || RPT_W < 1) begin : g_bad_cfg
    $error("input_conditioner: invalid parameter configuration");
  end

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  logic [NumCh-1:0]   sync1_q, sync2_q;
  logic [NumCh-1:0]   level_w;
  logic [NUM_BTN-1:0] accept_w;
`ifdef INPUT_COND_AUTOREPEAT_EN
  logic [NUM_BTN-1:0] stay_w;
`endif

  // Buttons occupy the low channel indices, switches the high ones.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_raw, btn_raw};
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NumCh; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StIdle: begin
          if (sync2_q[i]) begin
            state_d = StPressWait;
            cnt_d   = '0;
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            state_d = StReleaseWait;
            cnt_d   = '0;
          end
        end
        StReleaseWait: begin
          if (sync2_q[i]) begin
            state_d = StPressed;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= (state_d == StPressed) || (state_d == StReleaseWait);
      end
    end

    assign level_w[i] = level_q;

    if (i < NUM_BTN) begin : g_btn_tap
      assign accept_w[i] = (state_q == StPressWait) && (state_d == StPressed);
`ifdef INPUT_COND_AUTOREPEAT_EN
      assign stay_w[i] = (state_q == StPressed) && (state_d == StPressed);
`endif
    end
  end

  for (genvar j = 0; j < NUM_BTN; j++) begin : g_pulse
    logic pulse_q;
`ifdef INPUT_COND_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d, rpt_target;
    logic             first_q, first_d, hit;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; any exit re-arms the delay.
    assign rpt_target = first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);

    always_comb begin
      rpt_d   = rpt_q;
      first_d = first_q;
      hit     = 1'b0;
      if (stay_w[j]) begin
        if (rpt_q == rpt_target) begin
          hit     = 1'b1;
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end else begin
        rpt_d   = '0;
        first_d = 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
        rpt_q   <= '0;
        first_q <= 1'b1;
        pulse_q <= 1'b0;
      end else begin
        rpt_q   <= rpt_d;
        first_q <= first_d;
        pulse_q <= accept_w[j] | hit;
      end
    end
`else
    always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= accept_w[j];
      end
    end
`endif
    assign btn_pulse[j] = pulse_q;
  end

  assign btn_level = level_w[NUM_BTN-1:0];
  assign sw_level  = level_w[NumCh-1:NUM_BTN];

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end conditioning stage directly upstream of the MIPS CPU's switch and button inputs (SW0..SW2, btnL, btnR).
- Synchronizes the raw board inputs into the CLK domain and debounces them.
- Emits debounced levels for switches and buttons, plus a one-cycle press pulse per button, so CPU software polls clean values.
- Sits at the top level between the board pins and the CPU instance, on CLK.

Parameters:
- NUM_BTN, 2, number of push-button channels (btnL = bit 1, btnR = bit 0).
- NUM_SW, 3, number of slide-switch channels (SW2..SW0).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); minimum 2.
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat pulse (used only with INPUT_COND_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (used only with INPUT_COND_AUTOREPEAT_EN).
- RPT_W, 26, repeat counter width.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_raw  input  NUM_BTN  raw, bouncy, asynchronous button pins.
- sw_raw  input  NUM_SW  raw, asynchronous switch pins.
- btn_level  output  NUM_BTN  debounced button state, 1 = pressed.
- btn_pulse  output  NUM_BTN  one-cycle strobe on each accepted press.
- sw_level  output  NUM_SW  debounced switch state.

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer flops, counters, states and outputs go to 0; every channel enters IDLE. Deassertion takes effect at the next rising edge.
- Synchronizer:
  - Each raw bit passes through two flops, giving synchronized value s.
  - Raw-to-s latency is 2 edges. No other logic samples raw inputs.
- Per-channel filter FSM (identical for buttons and switches), states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: if s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if s=0, go to IDLE with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED. Else cnt+1.
  - PRESSED: if s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT: if s=1, go to PRESSED with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Else cnt+1.
  - Counter never wraps; it is cleared on every state change.
- Outputs:
  - level is registered and equals 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
  - For constant-high raw first sampled at edge 1, level rises at edge DEBOUNCE_CYCLES+3. Falling latency is symmetric.
- Pulse (buttons only):
  - btn_pulse[i] is high for exactly the one cycle following the PRESS_WAIT->PRESSED transition, coincident with the first cycle of level=1.
  - No pulse on release.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level or produces a pulse.
- Channels are fully independent. Simultaneous presses give simultaneous pulses.
- Inputs held high through reset are seen as 0 at reset release, then accepted after the normal debounce time. A button held through reset therefore yields one pulse.
- Reset mid-debounce discards the partial count.

Optional Feature:
- Macro: INPUT_COND_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a per-button repeat counter runs.
  - An extra one-cycle btn_pulse fires after REPEAT_DELAY cycles in PRESSED, then every REPEAT_PERIOD cycles while in PRESSED.
  - The counter clears when leaving PRESSED, including on entry to RELEASE_WAIT.
  - A bounce back to PRESSED restarts the delay without a new initial pulse.
- Undefined: no repeat counters are synthesized; exactly one pulse per accepted press. REPEAT_* parameters are ignored.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, CNT_W=3.
- Reset: assert rst=0 with all raw=1 mid-run -> all outputs 0 immediately. Release -> btn_level=11 and one btn_pulse=11 cycle at edge 7 after release.
- Clean press: btn_raw[0] 0->1 held -> btn_level[0] rises at edge 7, btn_pulse[0]=1 for exactly one cycle. Release -> level falls at edge 7 after release, with no pulse.
- Bounce: btn_raw[1] toggles 1,1,1,0 repeatedly for 40 cycles, then stays 1 -> no level change or pulse during toggling, then one pulse 7 edges after the final stable rise.
- Switches: sw_raw 000->101 -> sw_level=101 at edge 7. A 3-cycle 1->0->1 glitch on SW0 -> sw_level unchanged.
- Independence: both buttons pressed 2 cycles apart -> two pulses 2 cycles apart. Pressing one button mid-debounce on the other does not disturb it.
- Autorepeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, hold 30 cycles) -> pulses at the accept cycle, +10, +15, +20, +25. Macro undefined -> single pulse.
